// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide engine and HI/LO register owner.
// MULT/MULTU use a shift-add multiplier, DIV/DIVU a restoring divider;
// both run on operand magnitudes for WIDTH cycles, then a single FIX
// cycle applies the result signs and writes HI/LO.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start_EX,
  input  logic [1:0]       MdOp_EX,
  input  logic [WIDTH-1:0] OperandA_EX,
  input  logic [WIDTH-1:0] OperandB_EX,
  input  logic             WriteHi_EX,
  input  logic             WriteLo_EX,
  input  logic [WIDTH-1:0] WriteData_EX,
  input  logic             HiLoUse_ID,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic             Stall_MD
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;     // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q, acc_d;         // product, or dividend/quotient in low half
  logic [WIDTH-1:0]   rem_q, rem_d;         // partial remainder
  logic               neg_lo_q, neg_lo_d;   // negate product / quotient
  logic               neg_hi_q, neg_hi_d;   // negate remainder
  logic               is_div_q, is_div_d;
  logic               dz_q, dz_d;           // divisor was zero
  logic [WIDTH-1:0]   opa_q, opa_d;         // raw dividend for the divide-by-zero result
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dbz_q, dbz_d;

  logic               op_signed;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               accepting;

  // State and datapath registers; reset discards any operation in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
      opa_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      is_div_q <= is_div_d;
      dz_q     <= dz_d;
      opa_q    <= opa_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
    end
  end

  // Arithmetic helpers: operand magnitudes, one iteration step, sign fix
  always_comb begin
    op_signed = ~MdOp_EX[0];
    sign_a    = op_signed & OperandA_EX[WIDTH-1];
    sign_b    = op_signed & OperandB_EX[WIDTH-1];
    mag_a     = sign_a ? -OperandA_EX : OperandA_EX;
    mag_b     = sign_b ? -OperandB_EX : OperandB_EX;

    // Shift-add: add multiplicand into the upper half when the current
    // multiplier bit (acc[0]) is set, carry kept in the extra sum bit.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);

    // Restoring divide: shifted remainder carries one guard bit so the
    // trial subtraction never loses the top bit.
    div_shift = {rem_q, acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mcand_q};

    prod_fix  = neg_lo_q ? -acc_q : acc_q;
    quo_fix   = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = neg_hi_q ? -rem_q : rem_q;
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    is_div_d = is_div_q;
    dz_d     = dz_q;
    opa_d    = opa_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
    accepting = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        accepting = 1'b1;
        state_d   = S_IDLE;
        if (Start_EX) begin
          // Start has priority over a same-cycle MTHI/MTLO
          count_d  = '0;
          neg_lo_d = sign_a ^ sign_b;
          neg_hi_d = sign_a;
          is_div_d = MdOp_EX[1];
          dz_d     = (OperandB_EX == '0);
          opa_d    = OperandA_EX;
          rem_d    = '0;
          dbz_d    = 1'b0;
          if (MdOp_EX[1]) begin
            mcand_d = mag_b;
            acc_d   = {{WIDTH{1'b0}}, mag_a};
            state_d = S_DIV;
          end else begin
            mcand_d = mag_a;
            acc_d   = {{WIDTH{1'b0}}, mag_b};
            state_d = S_MUL;
          end
        end else begin
          if (WriteHi_EX) hi_d = WriteData_EX;
          if (WriteLo_EX) lo_d = WriteData_EX;
        end
      end

      S_MUL: begin
        acc_d   = {mul_sum, acc_q[WIDTH-1:1]};
        count_d = count_q + 1'b1;
        if (count_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end

      S_DIV: begin
        if (!div_diff[WIDTH]) begin
          rem_d = div_diff[WIDTH-1:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = div_shift[WIDTH-1:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
        end
        count_d = count_q + 1'b1;
        if (count_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end

      S_FIX: begin
        state_d = S_DONE;
        if (is_div_q) begin
          if (dz_q) begin
            lo_d  = '1;
            hi_d  = opa_q;
            dbz_d = 1'b1;
          end else begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    Busy      = ~accepting;
    Done      = (state_q == S_DONE);
    Hi        = hi_q;
    Lo        = lo_q;
    DivByZero = dbz_q;
    Stall_MD  = Busy & HiLoUse_ID;
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  logic        clk;
  logic        reset;
  logic        Start_EX;
  logic [1:0]  MdOp_EX;
  logic [31:0] OperandA_EX;
  logic [31:0] OperandB_EX;
  logic        WriteHi_EX;
  logic        WriteLo_EX;
  logic [31:0] WriteData_EX;
  logic        HiLoUse_ID;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        Busy;
  logic        Done;
  logic        DivByZero;
  logic        Stall_MD;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .Start_EX     (Start_EX),
    .MdOp_EX      (MdOp_EX),
    .OperandA_EX  (OperandA_EX),
    .OperandB_EX  (OperandB_EX),
    .WriteHi_EX   (WriteHi_EX),
    .WriteLo_EX   (WriteLo_EX),
    .WriteData_EX (WriteData_EX),
    .HiLoUse_ID   (HiLoUse_ID),
    .Hi           (Hi),
    .Lo           (Lo),
    .Busy         (Busy),
    .Done         (Done),
    .DivByZero    (DivByZero),
    .Stall_MD     (Stall_MD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to the sample point 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a start for one cycle; returns at the first busy sample point
  task automatic do_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    Start_EX    = 1'b1;
    MdOp_EX     = op;
    OperandA_EX = a;
    OperandB_EX = b;
    step();
    Start_EX    = 1'b0;
  endtask

  // Count busy sample points, bounded; returns at the first non-busy sample
  task automatic wait_busy(output int n);
    n = 0;
    while (Busy === 1'b1 && n < 100) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    Start_EX = 1'b0; MdOp_EX = 2'b00; OperandA_EX = '0; OperandB_EX = '0;
    WriteHi_EX = 1'b0; WriteLo_EX = 1'b0; WriteData_EX = '0; HiLoUse_ID = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({Hi, Lo} !== 64'h0) begin
      n_fail++; $display("FAIL reset_hilo: got %h_%h expected 0_0", Hi, Lo);
    end
    n_checks++;
    if ({Busy, Done, DivByZero, Stall_MD} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000", {Busy, Done, DivByZero, Stall_MD});
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_mthi_mtlo();
    WriteHi_EX = 1'b1; WriteData_EX = 32'hAAAA5555;
    step();
    WriteHi_EX = 1'b0;
    n_checks++;
    if (Hi !== 32'hAAAA5555 || Lo !== 32'h0) begin
      n_fail++; $display("FAIL mthi: got %h/%h expected aaaa5555/00000000", Hi, Lo);
    end
    WriteHi_EX = 1'b1; WriteLo_EX = 1'b1; WriteData_EX = 32'h0F0F0F0F;
    step();
    WriteHi_EX = 1'b0; WriteLo_EX = 1'b0;
    n_checks++;
    if (Hi !== 32'h0F0F0F0F || Lo !== 32'h0F0F0F0F) begin
      n_fail++; $display("FAIL mthi_mtlo_both: got %h/%h expected 0f0f0f0f/0f0f0f0f", Hi, Lo);
    end
  endtask

  task automatic test_multu_max();
    int n;
    do_start(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_busy(n);
    n_checks++;
    if (n !== 33) begin
      n_fail++; $display("FAIL multu_busy_cycles: got %0d expected 33", n);
    end
    n_checks++;
    if (Done !== 1'b1) begin
      n_fail++; $display("FAIL multu_done: got %b expected 1", Done);
    end
    n_checks++;
    if (Hi !== 32'hFFFFFFFE || Lo !== 32'h00000001) begin
      n_fail++; $display("FAIL multu_result: got %h_%h expected fffffffe_00000001", Hi, Lo);
    end
    step();
    n_checks++;
    if (Done !== 1'b0 || Busy !== 1'b0) begin
      n_fail++; $display("FAIL multu_done_pulse: got done=%b busy=%b expected 0/0", Done, Busy);
    end
  endtask

  task automatic test_signed();
    int n;
    do_start(OP_MULT, 32'hFFFFFFFD, 32'd7);
    wait_busy(n);
    n_checks++;
    if (Hi !== 32'hFFFFFFFF || Lo !== 32'hFFFFFFEB || Done !== 1'b1) begin
      n_fail++; $display("FAIL mult_neg: got %h_%h done=%b expected ffffffff_ffffffeb done=1", Hi, Lo, Done);
    end
    do_start(OP_MULT, 32'h80000000, 32'h80000000);
    wait_busy(n);
    n_checks++;
    if (Hi !== 32'h40000000 || Lo !== 32'h00000000) begin
      n_fail++; $display("FAIL mult_minmin: got %h_%h expected 40000000_00000000", Hi, Lo);
    end
    do_start(OP_DIV, 32'hFFFFFFF9, 32'd2);
    wait_busy(n);
    n_checks++;
    if (Lo !== 32'hFFFFFFFD || Hi !== 32'hFFFFFFFF) begin
      n_fail++; $display("FAIL div_neg: got lo=%h hi=%h expected lo=fffffffd hi=ffffffff", Lo, Hi);
    end
    do_start(OP_DIVU, 32'd100, 32'd7);
    wait_busy(n);
    n_checks++;
    if (Lo !== 32'd14 || Hi !== 32'd2 || n !== 33) begin
      n_fail++; $display("FAIL divu_basic: got lo=%h hi=%h n=%0d expected lo=0000000e hi=00000002 n=33", Lo, Hi, n);
    end
  endtask

  task automatic test_div_by_zero();
    int n;
    do_start(OP_DIVU, 32'd100, 32'd0);
    wait_busy(n);
    n_checks++;
    if (Lo !== 32'hFFFFFFFF || Hi !== 32'd100 || DivByZero !== 1'b1 || n !== 33) begin
      n_fail++; $display("FAIL divu_zero: got lo=%h hi=%h dbz=%b n=%0d expected ffffffff/00000064/1/33", Lo, Hi, DivByZero, n);
    end
    step();
    n_checks++;
    if (DivByZero !== 1'b1) begin
      n_fail++; $display("FAIL dbz_hold: got %b expected 1", DivByZero);
    end
    do_start(OP_DIV, 32'hFFFFFFFB, 32'd0);
    n_checks++;
    if (DivByZero !== 1'b0) begin
      n_fail++; $display("FAIL dbz_clear_on_start: got %b expected 0", DivByZero);
    end
    wait_busy(n);
    n_checks++;
    if (Lo !== 32'hFFFFFFFF || Hi !== 32'hFFFFFFFB || DivByZero !== 1'b1) begin
      n_fail++; $display("FAIL div_zero_signed: got lo=%h hi=%h dbz=%b expected ffffffff/fffffffb/1", Lo, Hi, DivByZero);
    end
  endtask

  task automatic test_stall();
    int n, stall_bad, hi_bad;
    logic [31:0] hi_before;
    hi_before = Hi;
    do_start(OP_DIV, 32'd1000, 32'd3);
    n_checks++;
    if (Stall_MD !== 1'b0) begin
      n_fail++; $display("FAIL stall_without_use: got %b expected 0", Stall_MD);
    end
    HiLoUse_ID = 1'b1; WriteHi_EX = 1'b1; WriteData_EX = 32'h00001234;
    n = 1; stall_bad = 0; hi_bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (Busy !== 1'b1) break;
      n++;
      if (Stall_MD !== 1'b1) stall_bad++;
      if (Hi !== hi_before) hi_bad++;
    end
    n_checks++;
    if (n !== 33 || stall_bad !== 0) begin
      n_fail++; $display("FAIL stall_while_busy: got n=%0d low_cycles=%0d expected 33/0", n, stall_bad);
    end
    n_checks++;
    if (hi_bad !== 0) begin
      n_fail++; $display("FAIL mthi_ignored_busy: got %0d changed cycles expected 0", hi_bad);
    end
    n_checks++;
    if (Stall_MD !== 1'b0 || Done !== 1'b1 || Lo !== 32'd333 || Hi !== 32'd1) begin
      n_fail++; $display("FAIL stall_done_cycle: got stall=%b done=%b lo=%h hi=%h expected 0/1/0000014d/00000001", Stall_MD, Done, Lo, Hi);
    end
    HiLoUse_ID = 1'b0; WriteHi_EX = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    int n, dones;
    do_start(OP_MULT, 32'd5, 32'd5);
    repeat (9) step();
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (Hi !== 32'h0 || Lo !== 32'h0 || Busy !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got hi=%h lo=%h busy=%b expected 0/0/0", Hi, Lo, Busy);
    end
    step();
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (Done === 1'b1 || Busy === 1'b1) dones++;
    end
    n_checks++;
    if (dones !== 0) begin
      n_fail++; $display("FAIL reset_discard: got %0d active cycles expected 0", dones);
    end
    do_start(OP_MULTU, 32'd6, 32'd7);
    wait_busy(n);
    n_checks++;
    if (Lo !== 32'd42 || Hi !== 32'd0 || Done !== 1'b1) begin
      n_fail++; $display("FAIL multu_after_reset: got lo=%h hi=%h done=%b expected 0000002a/0/1", Lo, Hi, Done);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    do_start(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_busy(n);
    n_checks++;
    if (Lo !== 32'h80000000 || Hi !== 32'h0 || Done !== 1'b1 || DivByZero !== 1'b0) begin
      n_fail++; $display("FAIL div_overflow: got lo=%h hi=%h done=%b dbz=%b expected 80000000/0/1/0", Lo, Hi, Done, DivByZero);
    end
    WriteLo_EX = 1'b1; WriteData_EX = 32'h5A5A5A5A;
    do_start(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    WriteLo_EX = 1'b0;
    n_checks++;
    if (Busy !== 1'b1 || Lo !== 32'h80000000) begin
      n_fail++; $display("FAIL b2b_start_wins: got busy=%b lo=%h expected 1/80000000", Busy, Lo);
    end
    wait_busy(n);
    n_checks++;
    if (n !== 33 || Done !== 1'b1 || Lo !== 32'h80000000 || Hi !== 32'h0) begin
      n_fail++; $display("FAIL b2b_result: got n=%0d done=%b lo=%h hi=%h expected 33/1/80000000/0", n, Done, Lo, Hi);
    end
  endtask

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_multu_max();
    test_signed();
    test_div_by_zero();
    test_stall();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
